// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared widths, word-offset and write-buffer FSM encoding
// Rev 1.0
// ============================================================================
package cache_pkg;

  localparam int CACHE_ADDR_WIDTH = 32;
  localparam int CACHE_DATA_WIDTH = 32;
  localparam int WORD_LSB         = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2,
    RESP   = 2'd3
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : circular store buffer with youngest-first word-address search
// Rev 1.0
// ============================================================================
module wb_fifo
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [ADDR_WIDTH-1:0]        push_addr_i,
  input  logic [DATA_WIDTH-1:0]        push_data_i,
  input  logic                         pop_i,
  input  logic [ADDR_WIDTH-1:WORD_LSB] srch_word_i,
  output logic                         hit_o,
  output logic [DATA_WIDTH-1:0]        hit_data_o,
  output logic [ADDR_WIDTH-1:0]        head_addr_o,
  output logic [DATA_WIDTH-1:0]        head_data_o,
  output logic                         not_full_o,
  output logic                         empty_o
);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] srch_idx;

  // Storage carries no reset; validity is defined purely by head/count.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_d  = pop_i  ? head_q + PW'(1) : head_q;
    tail_d  = push_i ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match left standing is the youngest;
  // a store arriving this cycle is younger than anything held.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    srch_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      srch_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (addr_q[srch_idx][ADDR_WIDTH-1:WORD_LSB] == srch_word_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[srch_idx];
      end
    end
    if (push_i && (push_addr_i[ADDR_WIDTH-1:WORD_LSB] == srch_word_i)) begin
      hit_o      = 1'b1;
      hit_data_o = push_data_i;
    end
  end

  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign not_full_o  = (count_q < CW'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/cache_write_buffer.sv
`default_nettype none
// ============================================================================
// cache_write_buffer : write-through store buffer + read-miss port to memory
// Rev 1.0
// ============================================================================
module cache_write_buffer
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH = CACHE_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_miss_valid,
  input  logic [ADDR_WIDTH-1:0] rd_miss_addr,
  output logic                  rd_miss_ready,
  output logic                  rd_fill_valid,
  output logic [DATA_WIDTH-1:0] rd_fill_data,
  output logic                  buf_empty,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  wb_state_e             state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_hit;
  logic [DATA_WIDTH-1:0] fifo_hit_data;
  logic [ADDR_WIDTH-1:0] fifo_head_addr;
  logic [DATA_WIDTH-1:0] fifo_head_data;
  logic                  fifo_not_full;
  logic                  fifo_empty;

  assign fifo_push = wr_valid && fifo_not_full;

  wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .pop_i       (fifo_pop),
    .srch_word_i (rd_miss_addr[ADDR_WIDTH-1:WORD_LSB]),
    .hit_o       (fifo_hit),
    .hit_data_o  (fifo_hit_data),
    .head_addr_o (fifo_head_addr),
    .head_data_o (fifo_head_data),
    .not_full_o  (fifo_not_full),
    .empty_o     (fifo_empty)
  );

  // State and memory-side registers; reset drops mem_req without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Misses win arbitration in IDLE; every drain returns through IDLE so a
  // waiting miss always gets a slot between consecutive stores.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_data_d = fill_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_miss_valid) begin
          if (fifo_hit) begin
            fill_data_d = fifo_hit_data;
            state_d     = RESP;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = rd_miss_addr;
            state_d    = MEM_RD;
          end
        end else if (!fifo_empty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = fifo_head_addr;
          mem_wdata_d = fifo_head_data;
          state_d     = MEM_WR;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          fill_data_d = mem_rdata;
          state_d     = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          fifo_pop  = 1'b1;
          state_d   = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ready      = fifo_not_full;
    rd_miss_ready = (state_q == IDLE);
    rd_fill_valid = (state_q == RESP);
    buf_empty     = fifo_empty && (state_q == IDLE);
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rd_fill_data = fill_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_write_buffer.sv
`default_nettype none
// ============================================================================
// tb_cache_write_buffer : scoreboard bench for the write buffer / miss port
// Rev 1.0
// ============================================================================
module tb_cache_write_buffer;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_FILL = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_miss_valid;
  logic [31:0] rd_miss_addr;
  logic        rd_miss_ready;
  logic        rd_fill_valid;
  logic [31:0] rd_fill_data;
  logic        buf_empty;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  ev_t         exp_q[$];

  int          ack_delay = 0;
  logic        ack_block = 1'b0;
  logic        spur      = 1'b0;
  logic [31:0] rd_return = '0;

  cache_write_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_miss_valid (rd_miss_valid),
    .rd_miss_addr  (rd_miss_addr),
    .rd_miss_ready (rd_miss_ready),
    .rd_fill_valid (rd_fill_valid),
    .rd_fill_data  (rd_fill_data),
    .buf_empty     (buf_empty),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Memory model: ack after ack_delay request cycles unless blocked.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = rd_return;
      if (mem_req) begin
        mem_ack = !ack_block && (cnt >= ack_delay);
        cnt++;
      end else begin
        mem_ack = spur;
        cnt     = 0;
      end
    end
  end

  task automatic check_event(input int kind, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d addr %h data %h, required no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind != K_FILL) chk("event_addr", a, e.addr);
      if (e.kind != K_RD)   chk("event_data", d, e.data);
    end
  endtask

  // Monitor: completed memory transactions and fill pulses against the scoreboard.
  initial begin
    logic        p_req, p_ack, p_we;
    logic [31:0] p_addr, p_wdata;
    p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_req = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (mem_req && mem_ack)
          check_event(mem_we ? K_WR : K_RD, mem_addr, mem_wdata);
        if (rd_fill_valid)
          check_event(K_FILL, 32'h0, rd_fill_data);
        if (p_req && !p_ack && mem_req) begin
          chk("req_stable_we", {31'h0, mem_we}, {31'h0, p_we});
          chk("req_stable_addr", mem_addr, p_addr);
          chk("req_stable_wdata", mem_wdata, p_wdata);
        end
        p_req   = mem_req;
        p_ack   = mem_ack;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
      end
    end
  end

  // Stimulus tasks are entered and left 1 time unit after a rising edge.
  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    int t;
    t        = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wr_accept_timeout", {31'h0, (t < 200)}, 32'h1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] a);
    int t;
    t             = 0;
    rd_miss_valid = 1'b1;
    rd_miss_addr  = a;
    while (!rd_miss_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("miss_accept_timeout", {31'h0, (t < 200)}, 32'h1);
    @(posedge clk); #1;
    rd_miss_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (!(buf_empty && exp_q.size() == 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_timeout"}, {31'h0, (t < 300)}, 32'h1);
    chk({nm, "_buf_empty"}, {31'h0, buf_empty}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({nm, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({nm, "_mem_addr"}, mem_addr, 32'h0);
    chk({nm, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({nm, "_fill_valid"}, {31'h0, rd_fill_valid}, 32'h0);
    chk({nm, "_fill_data"}, rd_fill_data, 32'h0);
    chk({nm, "_wr_ready"}, {31'h0, wr_ready}, 32'h1);
    chk({nm, "_miss_ready"}, {31'h0, rd_miss_ready}, 32'h1);
    chk({nm, "_buf_empty"}, {31'h0, buf_empty}, 32'h1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_miss_valid = 1'b0; rd_miss_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single store drained with ack one cycle after req.
    ack_delay = 1;
    push_exp(K_WR, 32'h100, 32'hA5A5A5A5);
    do_wr(32'h100, 32'hA5A5A5A5);
    chk("drain_busy", {31'h0, buf_empty}, 32'h0);
    wait_drain("drain");

    // Fill the buffer while memory stalls; a fifth store must wait, not vanish.
    ack_delay = 0;
    ack_block = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(K_WR, 32'h1000 + 32'(4 * i), 32'hD0 + 32'(i));
    for (int i = 0; i < 4; i++) do_wr(32'h1000 + 32'(4 * i), 32'hD0 + 32'(i));
    chk("full_wr_ready", {31'h0, wr_ready}, 32'h0);
    fork
      do_wr(32'h1010, 32'hD4);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("full_held", {31'h0, wr_ready}, 32'h0);
        end
        ack_block = 1'b0;
      end
    join
    wait_drain("full");

    // Forwarding from the youngest of two buffered stores to one word.
    ack_block = 1'b1;
    rd_return = 32'h6666;
    push_exp(K_RD, 32'h600, 32'h0);
    push_exp(K_FILL, 32'h0, 32'h6666);
    push_exp(K_FILL, 32'h0, 32'h22);
    push_exp(K_WR, 32'h200, 32'h11);
    push_exp(K_WR, 32'h200, 32'h22);
    do_miss(32'h600);
    do_wr(32'h200, 32'h11);
    do_wr(32'h200, 32'h22);
    fork
      begin
        do_miss(32'h202);
        chk("fwd_fill_valid", {31'h0, rd_fill_valid}, 32'h1);
        chk("fwd_fill_data", rd_fill_data, 32'h22);
        chk("fwd_no_mem_req", {31'h0, mem_req}, 32'h0);
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        ack_block = 1'b0;
      end
    join
    wait_drain("forward");

    // Miss arriving right after a store beats the drain.
    ack_delay = 2;
    rd_return = 32'hBEEF;
    push_exp(K_RD, 32'h400, 32'h0);
    push_exp(K_FILL, 32'h0, 32'hBEEF);
    push_exp(K_WR, 32'h300, 32'h1);
    do_wr(32'h300, 32'h1);
    do_miss(32'h400);
    wait_drain("priority");

    // Store and miss to the same word in one cycle with the buffer empty.
    ack_delay = 0;
    push_exp(K_FILL, 32'h0, 32'h77);
    push_exp(K_WR, 32'h500, 32'h77);
    wr_valid = 1'b1; wr_addr = 32'h500; wr_data = 32'h77;
    rd_miss_valid = 1'b1; rd_miss_addr = 32'h500;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_miss_valid = 1'b0;
    chk("same_cycle_fill_valid", {31'h0, rd_fill_valid}, 32'h1);
    chk("same_cycle_fill_data", rd_fill_data, 32'h77);
    wait_drain("same_cycle");

    // Ack with no request outstanding.
    spur = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("spurious_req", {31'h0, mem_req}, 32'h0);
      chk("spurious_empty", {31'h0, buf_empty}, 32'h1);
    end
    spur = 1'b0;

    // Reset in the middle of a stalled write; nothing may survive it.
    ack_block = 1'b1;
    do_wr(32'h700, 32'h9);
    do_wr(32'h704, 32'hA);
    t = 0;
    while (!(mem_req && mem_we) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("midwr_reached", {31'h0, (t < 50)}, 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midwr");
    @(posedge clk); #1;
    rst = 1'b0;
    ack_block = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_req", {31'h0, mem_req}, 32'h0);
    chk("post_reset_empty", {31'h0, buf_empty}, 32'h1);
    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_write_buffer.md
# cache_write_buffer

Write-through store buffer and read-miss port between the direct-mapped L1 data cache and main memory. It absorbs every store the cache writes through, drains the stores to memory one at a time over a req/ack handshake, and services cache read misses. Read misses take priority over draining. A read miss that hits a buffered store is answered from the buffer so it never returns stale memory data.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width
- DEPTH, 4, buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  cache presents a write-through store
- wr_addr  in  ADDR_WIDTH  store byte address
- wr_data  in  DATA_WIDTH  store data
- wr_ready  out  1  buffer can accept a store this cycle
- rd_miss_valid  in  1  cache requests a word after a read miss
- rd_miss_addr  in  ADDR_WIDTH  miss byte address
- rd_miss_ready  out  1  miss request accepted this cycle
- rd_fill_valid  out  1  one-cycle pulse, fill data valid
- rd_fill_data  out  DATA_WIDTH  returned word
- buf_empty  out  1  no buffered stores and FSM in IDLE (fence indicator)
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completes the current request
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack

## Operation
- **Buffer.** Circular FIFO of {addr, data}, tracked by head, tail and count, with count in the range 0..DEPTH.
  - wr_ready = (count < DEPTH), combinational.
  - A store is enqueued when wr_valid && wr_ready. This is independent of FSM state.
- **Word match.** Compare addr[ADDR_WIDTH-1:2] only.
  - The youngest matching entry wins.
  - An incoming store in the same cycle counts as the youngest entry.
- **FSM states:** IDLE, MEM_RD, MEM_WR, RESP.
- **IDLE.** rd_miss_ready = 1.
  - If rd_miss_valid and the match search hits: latch the forwarded data into rd_fill_data and go to RESP.
  - If rd_miss_valid and the search misses: latch the address and go to MEM_RD.
  - Else if count > 0: go to MEM_WR, with the head entry loaded onto mem_addr/mem_wdata.
  - Else: stay in IDLE.
- **MEM_RD.** mem_req=1, mem_we=0, mem_addr = the miss address.
  - On mem_ack: rd_fill_data ← mem_rdata, go to RESP.
- **MEM_WR.** mem_req=1, mem_we=1, head entry presented.
  - On mem_ack: pop the head, go to IDLE.
- **RESP.** rd_fill_valid=1 for exactly one cycle, then go to IDLE.
- rd_miss_ready = 0 in every state except IDLE.

## Timing
- **Reset values:**
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - rd_fill_valid=0, rd_fill_data=0
  - wr_ready=1, rd_miss_ready=1, buf_empty=1
  - count=0, state=IDLE
- **Forwarded miss.** Accepted at edge N; rd_fill_valid is high in cycle N+1.
- **Memory miss.** Accepted at edge N; mem_req rises in cycle N+1. mem_ack sampled at edge M; rd_fill_valid is high in cycle M+1.
- **Drain.** Store-to-memory start is at least 1 cycle after entering IDLE with count>0.
- **Back-to-back drains.** One idle cycle separates them (MEM_WR→IDLE→MEM_WR). This gives pending misses an arbitration slot.
- **Request stability.** mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack is sampled. Zero-wait ack (ack in the first req cycle) is legal.
- **Spurious ack.** mem_ack while mem_req=0 is ignored.
- **Push and pop together.** An enqueue and a pop in the same cycle are allowed; count stays unchanged.
  - When full, the pop does not free space for an enqueue in the same cycle, because wr_ready depends on the registered count.
- **Ordering.** Stores reach memory in enqueue order. A store is never dropped while wr_ready=0; upstream holds it.
- **Reset mid-transaction.** Buffer contents and any in-flight request are discarded, and mem_req drops asynchronously.

## Structure
- Shared package cache_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - WORD_LSB = 2
  - the FSM state enum (IDLE, MEM_RD, MEM_WR, RESP)
- Sub-module wb_fifo: circular storage, head/tail/count, and a youngest-first word-address search with a hit flag and hit data output, including the same-cycle incoming store.
- Top level contains the FSM and the memory-side registers.

## Test plan
- **Drain.** Enqueue a store (0x100, 0xA5A5A5A5) with mem_ack one cycle after req → mem_req/mem_we high with those values, then buf_empty=1.
- **Full.** Enqueue 4 stores with mem_ack held low → wr_ready=0 after the 4th. A 5th store is held, not lost, and is accepted after the first ack. Memory sees all 5 in order.
- **Forward.** Buffer holds 0x200←0x11 then 0x200←0x22; issue miss at 0x202 → rd_fill_data=0x22 one cycle after acceptance, with no mem_req read.
- **Read priority.** Buffer holds 0x300←0x1; issue miss at 0x400 while in IDLE; memory returns 0xBEEF → read issued before the store; rd_fill_data=0xBEEF; the store drains afterwards.
- **Same-cycle hit.** wr_valid(0x500←0x77) and rd_miss_valid(0x500) in the same cycle with the buffer empty → rd_fill_data=0x77 forwarded.
- **Reset mid-write.** Assert rst during MEM_WR → mem_req=0 immediately, count=0, and every output at its reset value.
